md5_iter_core: RTL and testbench

// Folded, parametrised MD5 engine for the hash breaker: one 512-bit block per job, UNROLL rounds/cycle.

---
 rtl/md5_iter_core.sv | 196 +++++++++++++++++++
 tb/tb_md5_iter_core.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_iter_core.sv
`timescale 1ns/1ps
// md5_iter_core: folded single-block MD5 engine running UNROLL rounds per clock behind a valid/ready job port.
// Optional feature macro MD5_TARGET_CMP_EN adds target_hash / out_match digest comparison.
module md5_iter_core #(
  parameter int UNROLL = 4,
  parameter int TAG_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [447:0]     in_msg,
  input  logic [8:0]       in_len,
  input  logic [TAG_W-1:0] in_tag,
`ifdef MD5_TARGET_CMP_EN
  input  logic [127:0]     target_hash,
  output logic             out_match,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_digest,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             busy
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16) begin : g_bad_unroll
    $error("md5_iter_core: UNROLL must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } md5_state_t;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Indexed by {round group, round[1:0]}.
  localparam logic [4:0] S_TAB [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic md5_state_t md5_round(input md5_state_t s, input logic [5:0] i,
                                           input logic [511:0] blk);
    logic [31:0]  f;
    logic [3:0]   g;
    logic [511:0] blk_sh;
    logic [31:0]  sum;
    logic [63:0]  rot;
    case (i[5:4])
      2'd0:    begin f = (s.b & s.c) | (~s.b & s.d); g = i[3:0];          end
      2'd1:    begin f = (s.d & s.b) | (~s.d & s.c); g = 4'(5 * i + 1);   end
      2'd2:    begin f = s.b ^ s.c ^ s.d;            g = 4'(3 * i + 5);   end
      default: begin f = s.c ^ (s.b | ~s.d);         g = 4'(7 * i);       end
    endcase
    blk_sh = blk << {g, 5'b0};
    sum    = s.a + f + K_TAB[i] + bswap32(blk_sh[511:480]);
    rot    = {sum, sum} << S_TAB[{i[5:4], i[1:0]}];
    return '{a: s.d, b: s.b + rot[63:32], c: s.b, d: s.c};
  endfunction

  state_t       state, state_next;
  md5_state_t   hv, hv_next;
  logic [511:0] block, block_init;
  logic [447:0] msg_bits;
  logic [63:0]  len_bits;
  logic [6:0]   rnd;
  logic [127:0] digest_final;
  logic         accept, len_bad, last_cycle;

  assign accept     = in_valid && (state == S_IDLE);
  assign len_bad    = (in_len > 9'd447);
  assign last_cycle = ((rnd + 7'(UNROLL)) == 7'd64);

  // Keep the message bits, drop whatever sits below them, append the 1 marker and the LE bit length.
  assign msg_bits   = (in_msg & ~({448{1'b1}} >> in_len)) | ({1'b1, 447'b0} >> in_len);
  assign len_bits   = 64'(in_len);
  assign block_init = {msg_bits, bswap32(len_bits[31:0]), bswap32(len_bits[63:32])};

  always_comb begin
    hv_next = hv;
    for (int u = 0; u < UNROLL; u++) begin
      hv_next = md5_round(hv_next, 6'(rnd + 7'(u)), block);
    end
  end

  assign digest_final = {bswap32(hv_next.a + IV_A), bswap32(hv_next.b + IV_B),
                         bswap32(hv_next.c + IV_C), bswap32(hv_next.d + IV_D)};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block is assigned a default first, so no path leaves one undriven (no latch).
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = len_bad ? S_DONE : S_RUN;
      end
      S_RUN:   if (last_cycle) state_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: hash state and block have no reset: an accepted job always loads them before RUN reads them.
  always_ff @(posedge clk) begin
    if (accept && !len_bad) begin
      hv    <= '{a: IV_A, b: IV_B, c: IV_C, d: IV_D};
      block <= block_init;
    end else if (state == S_RUN) begin
      hv <= hv_next;
    end
  end

`ifdef MD5_TARGET_CMP_EN
  logic [127:0] target_q;

  always_ff @(posedge clk) begin
    if (accept) target_q <= target_hash;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rnd        <= '0;
      out_digest <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
`ifdef MD5_TARGET_CMP_EN
      out_match  <= 1'b0;
`endif
    end else if (accept) begin
      rnd     <= '0;
      out_tag <= in_tag;
      out_err <= len_bad;
      if (len_bad) begin
        out_digest <= '0;
`ifdef MD5_TARGET_CMP_EN
        out_match  <= 1'b0;
`endif
      end
    end else if (state == S_RUN) begin
      rnd <= rnd + 7'(UNROLL);
      if (last_cycle) begin
        out_digest <= digest_final;
        out_err    <= 1'b0;
`ifdef MD5_TARGET_CMP_EN
        out_match  <= (digest_final == target_q);
`endif
      end
    end
  end

endmodule

// File: tb/tb_md5_iter_core.sv
`timescale 1ns/1ps
// tb_md5_iter_core: directed MD5 vectors with known digests against cores built with UNROLL 4, 1 and 16.
module tb_md5_iter_core;

  localparam int NI = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid_v  [NI];
  logic         in_ready_v  [NI];
  logic         out_valid_v [NI];
  logic         out_ready_v [NI];
  logic         out_err_v   [NI];
  logic         busy_v      [NI];
  logic [127:0] out_digest_v [NI];
  logic [31:0]  out_tag_v    [NI];
  logic [447:0] in_msg = '0;
  logic [8:0]   in_len = '0;
  logic [31:0]  in_tag = '0;
`ifdef MD5_TARGET_CMP_EN
  logic [127:0] target_hash = '0;
  logic         out_match_v [NI];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_q [$];

  localparam logic [127:0] D_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
  localparam logic [127:0] D_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;

  string        vec_s [4] = '{"a", "message digest", "abcdefghijklmnopqrstuvwxyz",
                              "The quick brown fox jumps over the lazy dog"};
  logic [127:0] vec_d [4] = '{128'h0cc175b9c0f1b6a831c399e269772661,
                              128'hf96b697d7cb7938d525a2f31aaf161d0,
                              128'hc3fcd3d76192e4007dfb496cca67e13b,
                              128'h9e107d9d372bb6826bd81d3542a419d6};

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    md5_iter_core #(.UNROLL(gi == 0 ? 4 : (gi == 1 ? 1 : 16)), .TAG_W(32)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid_v[gi]),
      .in_ready   (in_ready_v[gi]),
      .in_msg     (in_msg),
      .in_len     (in_len),
      .in_tag     (in_tag),
`ifdef MD5_TARGET_CMP_EN
      .target_hash(target_hash),
      .out_match  (out_match_v[gi]),
`endif
      .out_valid  (out_valid_v[gi]),
      .out_ready  (out_ready_v[gi]),
      .out_digest (out_digest_v[gi]),
      .out_tag    (out_tag_v[gi]),
      .out_err    (out_err_v[gi]),
      .busy       (busy_v[gi])
    );
  end

  // Records the cycle of every job accepted by the UNROLL=4 core.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid_v[0] && in_ready_v[0]) acc_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [447:0] pack_str(input string s);
    logic [447:0] m;
    m = '0;
    for (int i = 0; i < s.len(); i++) m[447 - 8*i -: 8] = s[i];
    return m;
  endfunction

  // Called #1 after an edge; returns #1 after the accept edge with in_valid dropped.
  task automatic start_job(input int k, input logic [447:0] msg, input logic [8:0] len,
                           input logic [31:0] tag);
    int guard;
    in_msg = msg;
    in_len = len;
    in_tag = tag;
    in_valid_v[k] = 1'b1;
    guard = 0;
    while (!in_ready_v[k] && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_before_accept", in_ready_v[k], 1'b1);
    @(posedge clk); #1;
    in_valid_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output int lat);
    lat = 0;
    while (!out_valid_v[k] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic expect_result(input int k, input string name, input logic [127:0] dig,
                               input logic [31:0] tag, input logic err, input int exp_lat, input int lat);
    check({name, "/latency"}, lat, exp_lat);
    check({name, "/valid"},   out_valid_v[k], 1'b1);
    check({name, "/digest"},  out_digest_v[k], dig);
    check({name, "/tag"},     out_tag_v[k], tag);
    check({name, "/err"},     out_err_v[k], err);
  endtask

  task automatic drain(input int k, input string name);
    out_ready_v[k] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[k] = 1'b0;
    check({name, "/valid_after_drain"}, out_valid_v[k], 1'b0);
    check({name, "/ready_after_drain"}, in_ready_v[k], 1'b1);
  endtask

  task automatic hash_job(input int k, input string name, input logic [447:0] msg,
                          input logic [8:0] len, input logic [31:0] tag, input logic [127:0] dig,
                          input int exp_lat);
    int lat;
    start_job(k, msg, len, tag);
    wait_done(k, lat);
    expect_result(k, name, dig, tag, 1'b0, exp_lat, lat);
    drain(k, name);
  endtask

  initial begin
    logic [447:0] abc_msg;
    logic [447:0] junk_msg;
    int           lat;
    bit           saw_valid;

    for (int k = 0; k < NI; k++) begin
      in_valid_v[k]  = 1'b0;
      out_ready_v[k] = 1'b0;
    end
    abc_msg  = pack_str("abc");
    junk_msg = abc_msg | {24'h0, {424{1'b1}}};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < NI; k++) begin
      check("rst/in_ready",  in_ready_v[k], 1'b1);
      check("rst/out_valid", out_valid_v[k], 1'b0);
      check("rst/out_err",   out_err_v[k], 1'b0);
      check("rst/digest",    out_digest_v[k], '0);
      check("rst/tag",       out_tag_v[k], '0);
      check("rst/busy",      busy_v[k], 1'b0);
    end

    hash_job(0, "empty_u4", '0, 9'd0, 32'd1, D_EMPTY, 16);
    hash_job(1, "abc_u1", abc_msg, 9'd24, 32'd5, D_ABC, 64);
    hash_job(2, "abc_u16", abc_msg, 9'd24, 32'd5, D_ABC, 4);
    hash_job(0, "abc_masked_u4", junk_msg, 9'd24, 32'd6, D_ABC, 16);
    for (int v = 0; v < 4; v++)
      hash_job(0, $sformatf("vec%0d_u4", v), pack_str(vec_s[v]), 9'(8 * vec_s[v].len()),
               32'(100 + v), vec_d[v], 16);
    hash_job(2, "fox_u16", pack_str(vec_s[3]), 9'(8 * vec_s[3].len()), 32'd42, vec_d[3], 4);

    // Result held under back-pressure; a job offered meanwhile is ignored.
    start_job(0, abc_msg, 9'd24, 32'd5);
    wait_done(0, lat);
    expect_result(0, "stall", D_ABC, 32'd5, 1'b0, 16, lat);
    in_tag = 32'd99;
    in_valid_v[0] = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("stall/valid",    out_valid_v[0], 1'b1);
      check("stall/digest",   out_digest_v[0], D_ABC);
      check("stall/tag",      out_tag_v[0], 32'd5);
      check("stall/in_ready", in_ready_v[0], 1'b0);
    end
    in_valid_v[0] = 1'b0;
    drain(0, "stall");

    // Back-to-back jobs with both sides always willing.
    acc_q.delete();
    in_msg = abc_msg;
    in_len = 9'd24;
    in_tag = 32'd8;
    in_valid_v[0]  = 1'b1;
    out_ready_v[0] = 1'b1;
    repeat (60) @(posedge clk);
    #1 in_valid_v[0] = 1'b0;
    repeat (30) @(posedge clk);
    #1 out_ready_v[0] = 1'b0;
    check("b2b/jobs", acc_q.size() >= 3, 1'b1);
    for (int i = 1; i < acc_q.size(); i++)
      check("b2b/period", acc_q[i] - acc_q[i-1], 18);

    // Over-length jobs short-circuit to DONE with the error flag.
    start_job(0, {448{1'b1}}, 9'd448, 32'd7);
    wait_done(0, lat);
    expect_result(0, "err448", '0, 32'd7, 1'b1, 0, lat);
    drain(0, "err448");
    start_job(2, {448{1'b1}}, 9'd511, 32'd9);
    wait_done(2, lat);
    expect_result(2, "err511", '0, 32'd9, 1'b1, 0, lat);
    drain(2, "err511");
    start_job(0, {448{1'b1}}, 9'd447, 32'd10);
    wait_done(0, lat);
    check("len447/latency", lat, 16);
    check("len447/err", out_err_v[0], 1'b0);
    check("len447/tag", out_tag_v[0], 32'd10);
    drain(0, "len447");
    hash_job(0, "abc_after_err", abc_msg, 9'd24, 32'd11, D_ABC, 16);

    // Reset at rnd=32 silently drops the job.
    start_job(0, abc_msg, 9'd24, 32'd3);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("midrst/busy",     busy_v[0], 1'b0);
    check("midrst/in_ready", in_ready_v[0], 1'b1);
    check("midrst/valid",    out_valid_v[0], 1'b0);
    saw_valid = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid_v[0]) saw_valid = 1'b1;
    end
    check("midrst/no_valid", saw_valid, 1'b0);
    hash_job(0, "abc_after_rst", abc_msg, 9'd24, 32'd12, D_ABC, 16);

`ifdef MD5_TARGET_CMP_EN
    target_hash = D_ABC;
    start_job(0, abc_msg, 9'd24, 32'd20);
    wait_done(0, lat);
    check("cmp/abc_match", out_match_v[0], 1'b1);
    drain(0, "cmp_abc");
    start_job(0, pack_str("abd"), 9'd24, 32'd21);
    wait_done(0, lat);
    check("cmp/abd_match", out_match_v[0], 1'b0);
    drain(0, "cmp_abd");
    start_job(0, abc_msg, 9'd448, 32'd22);
    wait_done(0, lat);
    check("cmp/err_match", out_match_v[0], 1'b0);
    drain(0, "cmp_err");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
